// File: rtl/arashi_sched_pkg.sv
// Shared types and default widths for the arashi per-thread issue scheduler.
package arashi_sched_pkg;

  localparam int DEF_THREAD_NUM_WIDTH = 2;
  localparam int DEF_LAT_WIDTH        = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READY   = 2'd1,
    ISSUED  = 2'd2,
    BLOCKED = 2'd3
  } thread_state_e;

endpackage

// File: rtl/arashi_thread_slot.sv
// Lifecycle tracker for one hardware thread: state plus block-latency down-counter.
module arashi_thread_slot
  import arashi_sched_pkg::*;
#(
  parameter int LAT_WIDTH = DEF_LAT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start_i,
  input  logic                 kill_i,
  input  logic                 accept_i,
  input  logic                 wb_i,
  input  logic                 wb_block_i,
  input  logic [LAT_WIDTH-1:0] wb_lat_i,
  input  logic                 wb_halt_i,
  output logic                 is_ready_o,
  output logic                 is_active_o
);

  thread_state_e        state_q, state_d;
  logic [LAT_WIDTH-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Kill overrides everything; writeback is only meaningful while an instruction is in flight.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (kill_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE:    if (start_i) state_d = READY;
        READY:   if (accept_i) state_d = ISSUED;
        ISSUED: begin
          if (wb_i) begin
            if (wb_halt_i) begin
              state_d = IDLE;
            end else if (wb_block_i && (wb_lat_i != '0)) begin
              state_d = BLOCKED;
              cnt_d   = wb_lat_i;
            end else begin
              state_d = READY;
            end
          end
        end
        BLOCKED: begin
          if (cnt_q <= LAT_WIDTH'(1)) begin
            state_d = READY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - LAT_WIDTH'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    is_ready_o  = (state_q == READY);
    is_active_o = (state_q != IDLE);
  end

endmodule

// File: rtl/arashi_thread_scheduler.sv
// Round-robin issue scheduler over per-thread slots with a registered valid/ready offer.
// Defining ARASHI_SCHED_PERF_EN adds accept and bubble performance counters.
module arashi_thread_scheduler
  import arashi_sched_pkg::*;
#(
  parameter  int THREAD_NUM_WIDTH = DEF_THREAD_NUM_WIDTH,
  parameter  int LAT_WIDTH        = DEF_LAT_WIDTH,
  localparam int THREAD_NUM       = 1 << THREAD_NUM_WIDTH
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        start_valid_i,
  input  logic [THREAD_NUM_WIDTH-1:0] start_tid_i,
  input  logic                        kill_valid_i,
  input  logic [THREAD_NUM_WIDTH-1:0] kill_tid_i,
  output logic                        issue_valid_o,
  output logic [THREAD_NUM_WIDTH-1:0] issue_tid_o,
  input  logic                        issue_ready_i,
  input  logic                        wb_valid_i,
  input  logic [THREAD_NUM_WIDTH-1:0] wb_tid_i,
  input  logic                        wb_block_i,
  input  logic [LAT_WIDTH-1:0]        wb_lat_i,
  input  logic                        wb_halt_i,
`ifdef ARASHI_SCHED_PERF_EN
  output logic [31:0]                 perf_issue_cnt_o,
  output logic [31:0]                 perf_bubble_cnt_o,
  output logic [THREAD_NUM-1:0]       thread_active_o
`else
  output logic [THREAD_NUM-1:0]       thread_active_o
`endif
);

  logic                        issue_valid_q, issue_valid_d;
  logic [THREAD_NUM_WIDTH-1:0] issue_tid_q, issue_tid_d;
  logic [THREAD_NUM_WIDTH-1:0] last_tid_q, last_tid_d;
  logic [THREAD_NUM-1:0]       slot_ready, slot_active, cand;
  logic                        accept, kill_offered, load;
  logic                        pick_valid;
  logic [THREAD_NUM_WIDTH-1:0] pick_tid, idx;

  assign accept       = issue_valid_q && issue_ready_i;
  assign kill_offered = kill_valid_i && issue_valid_q && (kill_tid_i == issue_tid_q);
  assign load         = !issue_valid_q || accept || kill_offered;

  for (genvar t = 0; t < THREAD_NUM; t++) begin : g_slot
    arashi_thread_slot #(.LAT_WIDTH(LAT_WIDTH)) u_slot (
      .clk        (clk),
      .rstn       (rstn),
      .start_i    (start_valid_i && (start_tid_i == THREAD_NUM_WIDTH'(t))),
      .kill_i     (kill_valid_i && (kill_tid_i == THREAD_NUM_WIDTH'(t))),
      .accept_i   (accept && (issue_tid_q == THREAD_NUM_WIDTH'(t))),
      .wb_i       (wb_valid_i && (wb_tid_i == THREAD_NUM_WIDTH'(t))),
      .wb_block_i (wb_block_i),
      .wb_lat_i   (wb_lat_i),
      .wb_halt_i  (wb_halt_i),
      .is_ready_o (slot_ready[t]),
      .is_active_o(slot_active[t])
    );
  end

  // The offered thread is still READY this cycle and a thread being killed is about to
  // leave READY, so neither may be picked into the offer slot.
  always_comb begin
    cand       = slot_ready;
    pick_valid = 1'b0;
    pick_tid   = '0;
    idx        = '0;
    if (issue_valid_q) cand[issue_tid_q] = 1'b0;
    if (kill_valid_i) cand[kill_tid_i] = 1'b0;
    for (int i = 0; i < THREAD_NUM; i++) begin
      idx = last_tid_q + THREAD_NUM_WIDTH'(i + 1);
      if (!pick_valid && cand[idx]) begin
        pick_valid = 1'b1;
        pick_tid   = idx;
      end
    end
  end

  always_comb begin
    issue_valid_d = issue_valid_q;
    issue_tid_d   = issue_tid_q;
    last_tid_d    = accept ? issue_tid_q : last_tid_q;
    if (load) begin
      issue_valid_d = pick_valid;
      if (pick_valid) issue_tid_d = pick_tid;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      issue_valid_q <= 1'b0;
      issue_tid_q   <= '0;
      last_tid_q    <= THREAD_NUM_WIDTH'(THREAD_NUM - 1);
    end else begin
      issue_valid_q <= issue_valid_d;
      issue_tid_q   <= issue_tid_d;
      last_tid_q    <= last_tid_d;
    end
  end

  assign issue_valid_o   = issue_valid_q;
  assign issue_tid_o     = issue_tid_q;
  assign thread_active_o = slot_active;

`ifdef ARASHI_SCHED_PERF_EN
  logic [31:0] perf_issue_q, perf_bubble_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      perf_issue_q  <= '0;
      perf_bubble_q <= '0;
    end else begin
      if (accept) perf_issue_q <= perf_issue_q + 32'd1;
      if (!issue_valid_q && (|slot_active)) perf_bubble_q <= perf_bubble_q + 32'd1;
    end
  end

  assign perf_issue_cnt_o  = perf_issue_q;
  assign perf_bubble_cnt_o = perf_bubble_q;
`endif

endmodule

// File: tb/tb_arashi_thread_scheduler.sv
// Directed and randomized bench for arashi_thread_scheduler against a time-based thread model.
// Also checks the perf counters when ARASHI_SCHED_PERF_EN is defined.
module tb_arashi_thread_scheduler;

  localparam int TW = 2;
  localparam int N  = 4;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic          startValid, killValid, issueReady, wbValid, wbBlock, wbHalt;
  logic [TW-1:0] startTid, killTid, wbTid;
  logic [LW-1:0] wbLat;
  logic          issueValid;
  logic [TW-1:0] issueTid;
  logic [N-1:0]  threadActive;
`ifdef ARASHI_SCHED_PERF_EN
  logic [31:0]   perfIssue, perfBubble;
`endif

  always #5 clk = ~clk;

  arashi_thread_scheduler #(.THREAD_NUM_WIDTH(TW), .LAT_WIDTH(LW)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .start_valid_i  (startValid),
    .start_tid_i    (startTid),
    .kill_valid_i   (killValid),
    .kill_tid_i     (killTid),
    .issue_valid_o  (issueValid),
    .issue_tid_o    (issueTid),
    .issue_ready_i  (issueReady),
    .wb_valid_i     (wbValid),
    .wb_tid_i       (wbTid),
    .wb_block_i     (wbBlock),
    .wb_lat_i       (wbLat),
    .wb_halt_i      (wbHalt),
`ifdef ARASHI_SCHED_PERF_EN
    .perf_issue_cnt_o (perfIssue),
    .perf_bubble_cnt_o(perfBubble),
`endif
    .thread_active_o(threadActive)
  );

  // Model: a thread is READY when started, not in flight, and the edge count has reached its wake time.
  bit              mActive[N];
  bit              mInFlight[N];
  int              mWake[N];
  bit              mOfferValid;
  int              mOfferTid;
  int              mLast;
  bit              mTidKnown;
  int              now;
  longint unsigned mIssues, mBubbles;

  int vectors = 0;
  int miscompares = 0;
  int acceptLog[$];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit isReady(int t);
    return mActive[t] && !mInFlight[t] && (now >= mWake[t]);
  endfunction

  task automatic modelReset();
    for (int t = 0; t < N; t++) begin
      mActive[t]   = 1'b0;
      mInFlight[t] = 1'b0;
      mWake[t]     = 0;
    end
    mOfferValid = 1'b0;
    mOfferTid   = 0;
    mLast       = N - 1;
    mTidKnown   = 1'b1;
    mIssues     = 0;
    mBubbles    = 0;
  endtask

  task automatic modelStep(input bit rst, input bit st, input int stT, input bit kl, input int klT,
                           input bit rdy, input bit wb, input int wbT, input bit blk, input int lat,
                           input bit hlt);
    bit cand[N];
    bit accept, reload, anyActive;
    int pick;
    if (rst) begin
      modelReset();
      now++;
      return;
    end
    accept    = mOfferValid && rdy;
    anyActive = 1'b0;
    for (int t = 0; t < N; t++) anyActive |= mActive[t];
    if (!mOfferValid && anyActive) mBubbles++;
    if (accept) mIssues++;
    for (int t = 0; t < N; t++)
      cand[t] = isReady(t) && !(mOfferValid && t == mOfferTid) && !(kl && t == klT);
    pick = -1;
    for (int k = 1; k <= N; k++) begin
      int t;
      t = (mLast + k) % N;
      if (pick < 0 && cand[t]) pick = t;
    end
    reload = !mOfferValid || accept || (kl && mOfferValid && klT == mOfferTid);
    now++;
    for (int t = 0; t < N; t++) begin
      if (kl && klT == t) begin
        mActive[t] = 0; mInFlight[t] = 0; mWake[t] = 0;
      end else if (wb && wbT == t && mInFlight[t]) begin
        mInFlight[t] = 0;
        if (hlt) begin
          mActive[t] = 0; mWake[t] = 0;
        end else begin
          mWake[t] = (blk && lat != 0) ? now + lat : 0;
        end
      end else if (st && stT == t && !mActive[t]) begin
        mActive[t] = 1; mWake[t] = 0;
      end else if (accept && mOfferTid == t) begin
        mInFlight[t] = 1;
      end
    end
    if (accept) mLast = mOfferTid;
    if (reload) begin
      mOfferValid = (pick >= 0);
      if (pick >= 0) mOfferTid = pick;
    end
    mTidKnown = 1'b0;
  endtask

  task automatic checkState();
    logic [N-1:0] expActive;
    for (int t = 0; t < N; t++) expActive[t] = mActive[t];
    checkOutput("issue_valid", 32'(issueValid), 32'(mOfferValid));
    if (mOfferValid || mTidKnown) checkOutput("issue_tid", 32'(issueTid), 32'(mOfferTid));
    checkOutput("thread_active", 32'(threadActive), 32'(expActive));
`ifdef ARASHI_SCHED_PERF_EN
    checkOutput("perf_issue", perfIssue, 32'(mIssues));
    checkOutput("perf_bubble", perfBubble, 32'(mBubbles));
`endif
  endtask

  task automatic applyStimulus(input bit rst, input bit st, input int stT, input bit kl, input int klT,
                               input bit rdy, input bit wb, input int wbT, input bit blk,
                               input int lat, input bit hlt);
    rstn       = !rst;
    startValid = st;
    startTid   = TW'(stT);
    killValid  = kl;
    killTid    = TW'(klT);
    issueReady = rdy;
    wbValid    = wb;
    wbTid      = TW'(wbT);
    wbBlock    = blk;
    wbLat      = LW'(lat);
    wbHalt     = hlt;
    if (!rst && issueValid === 1'b1 && rdy) acceptLog.push_back(int'(issueTid));
    @(posedge clk);
    modelStep(rst, st, stT, kl, klT, rdy, wb, wbT, blk, lat, hlt);
    #1;
    checkState();
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, rdy, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired observed=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int expOrder[8];
    int pendWb, accTid;
    expOrder = '{0, 1, 2, 3, 0, 1, 2, 3};
    now = 0;
    modelReset();

    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("reset_active", 32'(threadActive), 32'd0);
    checkOutput("reset_tid", 32'(issueTid), 32'd0);

    $display("[TB] round-robin order with back-to-back accepts");
    acceptLog.delete();
    pendWb = -1;
    for (int s = 0; s < 12; s++) begin
      accTid = (issueValid === 1'b1) ? int'(issueTid) : -1;
      applyStimulus(0, s < 4, s % 4, 0, 0, 1, pendWb >= 0, (pendWb < 0) ? 0 : pendWb, 0, 0, 0);
      pendWb = accTid;
    end
    checkOutput("order_count_ge8", 32'(acceptLog.size() >= 8), 32'd1);
    for (int i = 0; i < 8; i++)
      if (i < acceptLog.size()) checkOutput($sformatf("order_%0d", i), acceptLog[i], expOrder[i]);
    for (int t = 0; t < N; t++) applyStimulus(0, 0, 0, 1, t, 0, 0, 0, 0, 0, 0);
    idle(2, 0);
    checkOutput("cleanup_active", 32'(threadActive), 32'd0);

    $display("[TB] offer held under backpressure");
    applyStimulus(0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      idle(1, 0);
      checkOutput("hold_valid", 32'(issueValid), 32'd1);
      checkOutput("hold_tid", 32'(issueTid), 32'd2);
    end
    idle(1, 1);
    for (int i = 0; i < 3; i++) begin
      idle(1, 1);
      checkOutput("no_reoffer", 32'(issueValid), 32'd0);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 1);

    $display("[TB] blocking writeback latency 3");
    applyStimulus(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 1, 3, 0);
    for (int i = 1; i <= 3; i++) begin
      idle(1, 0);
      checkOutput($sformatf("blocked_k+%0d", i), 32'(issueValid), 32'd0);
    end
    idle(1, 0);
    checkOutput("wake_valid", 32'(issueValid), 32'd1);
    checkOutput("wake_tid", 32'(issueTid), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1);

    $display("[TB] kill of offered thread");
    applyStimulus(0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0);
    checkOutput("kill_valid", 32'(issueValid), 32'd0);
    checkOutput("kill_active3", 32'(threadActive[3]), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0);
    checkOutput("stale_wb_active", 32'(threadActive), 32'd0);
    checkOutput("stale_wb_valid", 32'(issueValid), 32'd0);

    $display("[TB] same-cycle kill, wb and start");
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 1, 1, 0, 0, 1, 0, 0, 0, 0);
    checkOutput("prio_active", 32'(threadActive), 32'b0010);
    checkOutput("prio_valid", 32'(issueValid), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1);

    $display("[TB] reset while blocked");
    applyStimulus(0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 2, 1, 7, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rst_valid", 32'(issueValid), 32'd0);
    checkOutput("rst_tid", 32'(issueTid), 32'd0);
    checkOutput("rst_active", 32'(threadActive), 32'd0);
    idle(9, 1);
    checkOutput("post_rst_active", 32'(threadActive), 32'd0);
    checkOutput("post_rst_valid", 32'(issueValid), 32'd0);

    $display("[TB] randomized traffic");
    for (int s = 0; s < 3000; s++) begin
      bit rst, st, kl, rdy, wb, blk, hlt;
      int stT, klT, wbT, lat;
      int inflight[$];
      rst = ($urandom_range(0, 199) == 0);
      st  = $urandom_range(0, 1);
      stT = $urandom_range(0, N - 1);
      kl  = ($urandom_range(0, 15) == 0);
      klT = $urandom_range(0, N - 1);
      rdy = ($urandom_range(0, 9) < 6);
      for (int t = 0; t < N; t++) if (mInFlight[t]) inflight.push_back(t);
      if (inflight.size() > 0 && $urandom_range(0, 9) < 7) begin
        wb  = 1;
        wbT = inflight[$urandom_range(0, inflight.size() - 1)];
      end else begin
        wb  = ($urandom_range(0, 7) == 0);
        wbT = $urandom_range(0, N - 1);
      end
      blk = $urandom_range(0, 1);
      lat = $urandom_range(0, 15);
      hlt = ($urandom_range(0, 9) == 0);
      applyStimulus(rst, st, stT, kl, klT, rdy, wb, wbT, blk, lat, hlt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
